// File: rtl/cpu_rfread.sv
// Register-read stage: 8x16 register file with writeback port, operand read,
// and execute-stage pipeline register. Optional same-cycle bypass: CPU_RF_BYPASS_EN.
module cpu_rfread #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_instr,
  input  logic [DATA_W-1:0] rd_pc,
  input  logic              stall,
  input  logic              flush_r,
  input  logic              wb_wr,
  input  logic              wb_seven,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_instr,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rx,
  output logic [DATA_W-1:0] ex_ry,
  output logic [DATA_W-1:0] rx_dbg
);

  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] LINK_IDX = IDX_W'(NREGS - 1);

  logic [DATA_W-1:0] rf_q [NREGS];

  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rx_idx;
  logic [IDX_W-1:0]  ry_idx;
  logic [DATA_W-1:0] rx_val;
  logic [DATA_W-1:0] ry_val;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_instr_q, ex_instr_d;
  logic [DATA_W-1:0] ex_pc_q,    ex_pc_d;
  logic [DATA_W-1:0] ex_rx_q,    ex_rx_d;
  logic [DATA_W-1:0] ex_ry_q,    ex_ry_d;

  assign wr_idx = wb_seven ? LINK_IDX : wb_addr;
  assign rx_idx = rd_instr[7:5];
  assign ry_idx = rd_instr[10:8];

  // Operand read; the bypass forwards the in-flight writeback value.
  always_comb begin
    rx_val = rf_q[rx_idx];
    ry_val = rf_q[ry_idx];
`ifdef CPU_RF_BYPASS_EN
    if (wb_wr && (wr_idx == rx_idx)) rx_val = wb_data;
    if (wb_wr && (wr_idx == ry_idx)) ry_val = wb_data;
`endif
  end

  // Register file; writes ignore stall/flush, reset discards a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else if (wb_wr) begin
      rf_q[wr_idx] <= wb_data;
    end
  end

  // Execute-stage next state: flush outranks stall.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_instr_d = ex_instr_q;
    ex_pc_d    = ex_pc_q;
    ex_rx_d    = ex_rx_q;
    ex_ry_d    = ex_ry_q;
    if (flush_r) begin
      ex_valid_d = 1'b0;
    end else if (!stall) begin
      ex_valid_d = rd_valid;
      ex_instr_d = rd_instr;
      ex_pc_d    = rd_pc;
      ex_rx_d    = rx_val;
      ex_ry_d    = ry_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_instr_q <= '0;
      ex_pc_q    <= '0;
      ex_rx_q    <= '0;
      ex_ry_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_instr_q <= ex_instr_d;
      ex_pc_q    <= ex_pc_d;
      ex_rx_q    <= ex_rx_d;
      ex_ry_q    <= ex_ry_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_instr = ex_instr_q;
  assign ex_pc    = ex_pc_q;
  assign ex_rx    = ex_rx_q;
  assign ex_ry    = ex_ry_q;
  assign rx_dbg   = rx_val;

endmodule

// File: tb/tb_cpu_rfread.sv
// Bench for cpu_rfread: directed vector table plus a random model-driven run,
// both checked through an expected-result queue.
module tb_cpu_rfread;

  logic        clk = 1'b0;
  logic        reset, rd_valid, stall, flush_r, wb_wr, wb_seven;
  logic [15:0] rd_instr, rd_pc, wb_data;
  logic [2:0]  wb_addr;
  logic        ex_valid;
  logic [15:0] ex_instr, ex_pc, ex_rx, ex_ry, rx_dbg;

  cpu_rfread dut (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_instr(rd_instr),
    .rd_pc(rd_pc), .stall(stall), .flush_r(flush_r), .wb_wr(wb_wr),
    .wb_seven(wb_seven), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_rx(ex_rx), .ex_ry(ex_ry), .rx_dbg(rx_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, vld, stl, fl, wr, sev;
    logic [15:0] instr, pc;
    logic [2:0]  waddr;
    logic [15:0] wdata;
  } in_t;

  typedef struct {
    logic        chk_f;
    logic        valid;
    logic [15:0] instr, pc, rx, ry;
    logic        chk_dbg;
    logic [15:0] dbg;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];

`ifdef CPU_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [15:0] mk(input int rx, input int ry);
    logic [2:0] x, y;
    x = 3'(rx);
    y = 3'(ry);
    return {5'h0a, y, x, 5'h11};
  endfunction

  function automatic in_t mi(input logic rst, input logic vld, input logic [15:0] instr,
                             input logic [15:0] pc, input logic stl, input logic fl,
                             input logic wr, input logic sev, input logic [2:0] wa,
                             input logic [15:0] wd);
    in_t r;
    r.rst = rst; r.vld = vld; r.instr = instr; r.pc = pc; r.stl = stl; r.fl = fl;
    r.wr = wr; r.sev = sev; r.waddr = wa; r.wdata = wd;
    return r;
  endfunction

  function automatic exp_t me(input logic chk_f, input logic v, input logic [15:0] instr,
                              input logic [15:0] pc, input logic [15:0] rx, input logic [15:0] ry);
    exp_t r;
    r.chk_f = chk_f; r.valid = v; r.instr = instr; r.pc = pc; r.rx = rx; r.ry = ry;
    r.chk_dbg = 1'b0; r.dbg = '0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic step(input in_t i, input exp_t e);
    exp_t got;
    @(negedge clk);
    reset = i.rst; rd_valid = i.vld; rd_instr = i.instr; rd_pc = i.pc;
    stall = i.stl; flush_r = i.fl; wb_wr = i.wr; wb_seven = i.sev;
    wb_addr = i.waddr; wb_data = i.wdata;
    #1;
    if (e.chk_dbg) chk("rx_dbg", rx_dbg, e.dbg);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk("ex_valid", 16'(ex_valid), 16'(got.valid));
    if (got.chk_f) begin
      chk("ex_instr", ex_instr, got.instr);
      chk("ex_pc", ex_pc, got.pc);
      chk("ex_rx", ex_rx, got.rx);
      chk("ex_ry", ex_ry, got.ry);
    end
  endtask

  // Independent reference state for the random phase.
  logic [15:0] m_rf [8];
  logic        m_valid, m_known;
  logic [15:0] m_instr, m_pc, m_rx, m_ry;

  function automatic logic [15:0] m_read(input logic [2:0] idx, input in_t i);
    logic [2:0] d;
    d = i.sev ? 3'd7 : i.waddr;
    if (BYP && i.wr && d == idx) return i.wdata;
    return m_rf[idx];
  endfunction

  vec_t tbl[$];

  initial begin
    logic [15:0] r4_raw, r7_raw;
    reset = 1'b1; rd_valid = 0; rd_instr = '0; rd_pc = '0; stall = 0; flush_r = 0;
    wb_wr = 0; wb_seven = 0; wb_addr = '0; wb_data = '0;

    r4_raw = BYP ? 16'h1234 : 16'h5555;
    r7_raw = BYP ? 16'h0040 : 16'h0000;

    tbl.push_back('{mi(1,0,mk(0,0),16'h0000,0,0,0,0,3'd0,16'h0), me(1,0,16'h0,16'h0,16'h0,16'h0)});
    tbl.push_back('{mi(0,1,mk(3,5),16'h0100,0,0,0,0,3'd0,16'h0), me(1,1,mk(3,5),16'h0100,16'h0,16'h0)});
    tbl.push_back('{mi(0,0,mk(0,0),16'h0102,0,0,1,0,3'd2,16'hBEEF), me(1,0,mk(0,0),16'h0102,16'h0,16'h0)});
    tbl.push_back('{mi(0,1,mk(2,1),16'h0104,0,0,1,0,3'd4,16'h5555), me(1,1,mk(2,1),16'h0104,16'hBEEF,16'h0)});
    tbl.push_back('{mi(0,1,mk(2,4),16'h0106,0,0,1,0,3'd4,16'h1234), me(1,1,mk(2,4),16'h0106,16'hBEEF,r4_raw)});
    tbl.push_back('{mi(0,1,mk(4,7),16'h0108,0,0,1,1,3'd1,16'h0040), me(1,1,mk(4,7),16'h0108,16'h1234,r7_raw)});
    tbl.push_back('{mi(0,1,mk(1,7),16'h010a,0,0,0,0,3'd0,16'h0), me(1,1,mk(1,7),16'h010a,16'h0,16'h0040)});
    tbl.push_back('{mi(0,1,mk(2,7),16'h0200,0,0,0,0,3'd0,16'h0), me(1,1,mk(2,7),16'h0200,16'hBEEF,16'h0040)});
    tbl.push_back('{mi(0,1,mk(4,1),16'h0204,1,0,1,0,3'd2,16'h7777), me(1,1,mk(2,7),16'h0200,16'hBEEF,16'h0040)});
    tbl.push_back('{mi(0,1,mk(4,1),16'h0204,1,0,0,0,3'd0,16'h0), me(1,1,mk(2,7),16'h0200,16'hBEEF,16'h0040)});
    tbl.push_back('{mi(0,1,mk(4,1),16'h0204,1,0,0,0,3'd0,16'h0), me(1,1,mk(2,7),16'h0200,16'hBEEF,16'h0040)});
    tbl.push_back('{mi(0,1,mk(4,1),16'h0204,1,1,1,0,3'd3,16'h3333), me(0,0,16'h0,16'h0,16'h0,16'h0)});
    tbl.push_back('{mi(0,1,mk(3,2),16'h0208,0,0,0,0,3'd0,16'h0), me(1,1,mk(3,2),16'h0208,16'h3333,16'h7777)});
    tbl.push_back('{mi(0,1,mk(4,7),16'h020a,0,0,0,0,3'd0,16'h0), me(1,1,mk(4,7),16'h020a,16'h1234,16'h0040)});
    tbl.push_back('{mi(1,1,mk(4,7),16'h020c,0,0,1,0,3'd5,16'hFFFF), me(1,0,16'h0,16'h0,16'h0,16'h0)});
    tbl.push_back('{mi(0,1,mk(5,2),16'h020e,0,0,0,0,3'd0,16'h0), me(1,1,mk(5,2),16'h020e,16'h0,16'h0)});
    tbl.push_back('{mi(0,1,mk(7,4),16'h0210,0,0,0,0,3'd0,16'h0), me(1,1,mk(7,4),16'h0210,16'h0,16'h0)});
    tbl.push_back('{mi(0,1,mk(3,3),16'h0212,0,1,0,0,3'd0,16'h0), me(0,0,16'h0,16'h0,16'h0,16'h0)});

    foreach (tbl[k]) begin
      vec_t v;
      v = tbl[k];
      v.e.chk_dbg = v.e.chk_f && !v.i.rst && !v.i.stl && !v.i.fl;
      v.e.dbg = v.e.rx;
      step(v.i, v.e);
    end

    // Random phase against the reference model, starting from reset.
    for (int n = 0; n < 400; n++) begin
      in_t  i;
      exp_t e;
      logic [15:0] rxv, ryv;
      logic [2:0]  dst;
      i.rst   = (n == 0) || ($urandom_range(0, 39) == 0);
      i.vld   = 1'($urandom);
      i.instr = 16'($urandom);
      i.pc    = 16'($urandom);
      i.stl   = ($urandom_range(0, 3) == 0);
      i.fl    = ($urandom_range(0, 7) == 0);
      i.wr    = 1'($urandom);
      i.sev   = ($urandom_range(0, 5) == 0);
      i.waddr = 3'($urandom);
      i.wdata = 16'($urandom);
      rxv = m_read(i.instr[7:5], i);
      ryv = m_read(i.instr[10:8], i);
      dst = i.sev ? 3'd7 : i.waddr;
      if (i.rst) begin
        foreach (m_rf[r]) m_rf[r] = '0;
        m_valid = 0; m_instr = '0; m_pc = '0; m_rx = '0; m_ry = '0; m_known = 1;
      end else begin
        if (i.wr) m_rf[dst] = i.wdata;
        if (i.fl) begin
          m_valid = 0; m_known = 0;
        end else if (!i.stl) begin
          m_valid = i.vld; m_instr = i.instr; m_pc = i.pc; m_rx = rxv; m_ry = ryv; m_known = 1;
        end
      end
      e = me(m_known, m_valid, m_instr, m_pc, m_rx, m_ry);
      e.chk_dbg = !i.rst;
      e.dbg = rxv;
      step(i, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_rfread.md
# cpu_rfread

Register-read stage of the 16-bit pipelined CPU. It holds the 8 x 16-bit register file and accepts the writeback stage's write port, including the r7 link write. It decodes the rX/rY fields of the instruction leaving fetch, reads both operands (with optional writeback bypass), and registers instruction, PC and operands into the execute stage under stall and flush control.

## Interface

- Parameters:
  - `DATA_W`, 16: register and datapath width.
  - `NREGS`, 8: number of architectural registers; index width is 3.
- Ports (reset is synchronous, active-high, on the rising edge of `clk`):
  - `clk`  in  1  single clock for the block.
  - `reset`  in  1  synchronous, active-high.
  - `rd_valid`  in  1  fetch presents a valid instruction.
  - `rd_instr`  in  16  instruction from fetch; rX = [7:5], rY = [10:8].
  - `rd_pc`  in  16  PC of that instruction.
  - `stall`  in  1  hold the execute-stage registers.
  - `flush_r`  in  1  squash the instruction entering execute.
  - `wb_wr`  in  1  write enable from writeback.
  - `wb_seven`  in  1  force the destination to r7; overrides `wb_addr`.
  - `wb_addr`  in  3  destination register, normally rX of the writeback instruction.
  - `wb_data`  in  16  write data, already muxed by writeback.
  - `ex_valid`  out  1  execute-stage instruction is live.
  - `ex_instr`  out  16  registered instruction.
  - `ex_pc`  out  16  registered PC.
  - `ex_rx`  out  16  registered rX operand.
  - `ex_ry`  out  16  registered rY operand.
  - `rx_dbg`  out  16  combinational register-file value of r[`rd_instr[7:5]`], for the trace port.

## Operation

- Write port:
  - The write is effective when `wb_wr` is high.
  - Destination = `wb_seven ? 3'd7 : wb_addr`.
  - The register updates on the clock edge.
  - Writes are never blocked by `stall` or `flush_r`.
- Read:
  - Operands are read combinationally from the rX/rY fields of `rd_instr`.
  - Reads happen regardless of opcode; execute ignores unused operands.
- Bypass (see Configuration): a read whose index equals the effective write destination in the same cycle returns `wb_data`.
- Execute-stage register update, in priority order:
  1. `reset`: all outputs 0, all registers 0.
  2. `flush_r`: `ex_valid` ← 0; other fields may load but are don't-care.
  3. `stall`: all ex_* hold.
  4. Otherwise: `ex_valid` ← `rd_valid`; `ex_instr`/`ex_pc`/`ex_rx`/`ex_ry` load.
- `flush_r` outranks `stall`: a flush during a stall still kills `ex_valid`.
- While stalled, `ex_rx`/`ex_ry` do not re-capture; RAW against writes during the stall is resolved by the hazard unit, not here.
- r7 behaves as an ordinary register except for the `wb_seven` routing.
- Both read ports addressing the same register return identical values.

## Timing

- Register file write: visible through the registers one cycle after the `wb_wr` edge. With bypass, it is visible in the same cycle.
- rd → ex latency: 1 cycle.
- Reset mid-operation:
  - Clears the register file and all ex_* on the next edge.
  - A simultaneous `wb_wr` is discarded.
- Simultaneous `wb_wr`, `stall` and `flush_r`: write happens, `ex_valid` = 0.
- Reset values of all outputs: 0.

## Configuration

- `CPU_RF_BYPASS_EN`:
  - **Defined:** same-cycle write-to-read forwarding on both rX and rY, and on `rx_dbg`.
  - **Undefined:** reads return the pre-write register contents, and the hazard unit must insert one bubble for writeback-to-read RAW.
- No other behaviour differs.

## Test plan

- **Reset then read:** assert `reset` 1 cycle, then present `rd_instr` with rX=3, rY=5, `rd_valid`=1 → next cycle `ex_valid`=1, `ex_rx`=0, `ex_ry`=0.
- **Write then read:** `wb_wr`=1, `wb_addr`=2, `wb_data`=16'hBEEF; next cycle read rX=2 → `ex_rx`=16'hBEEF one cycle later.
- **Same-cycle RAW:** `wb_wr`=1, `wb_addr`=4, `wb_data`=16'h1234 while `rd_instr` has rY=4.
  - Bypass on: `ex_ry`=16'h1234.
  - Bypass off: `ex_ry`=old r4.
- **r7 override:** `wb_seven`=1, `wb_addr`=1, `wb_data`=16'h0040 → r7=16'h0040, r1 unchanged.
- **Stall/flush:** load instruction A, then `stall`=1 for 3 cycles with a new `rd_instr` → ex_* hold A. Then `stall`=1 and `flush_r`=1 → `ex_valid`=0. Then release → next instruction loads.
- **Mid-stream reset:** registers hold nonzero values; assert `reset` together with `wb_wr` → all registers and ex_* read 0 afterwards.
